// File: rtl/sram_stream_pkg.sv
// rtl/sram_stream_pkg.sv - shared FSM state type and width helper for SRAM streams
package sram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width able to hold 0..fifo_depth outstanding reads
  function automatic int credit_bits(input int fifo_depth);
    return $clog2(fifo_depth + 1);
  endfunction

endpackage

// File: rtl/sram_rd_streamer_if.sv
// rtl/sram_rd_streamer_if.sv - command, write, stream and SRAM-side signals of the read streamer
interface sram_rd_streamer_if #(
  parameter int DATA_BIT = 64,
  parameter int ADDR_BIT = 10
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_BIT-1:0] cmd_addr;
  logic [ADDR_BIT:0]   cmd_len;
  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_BIT-1:0] wr_addr;
  logic [DATA_BIT-1:0] wr_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_BIT-1:0] out_data;
  logic                out_last;
  logic                done;
  logic [ADDR_BIT-1:0] sram_addr;
  logic                sram_wen;
  logic                sram_ren;
  logic [DATA_BIT-1:0] sram_wdata;
  logic [DATA_BIT-1:0] sram_rdata;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, wr_valid, wr_addr, wr_data, out_ready, sram_rdata,
    output cmd_ready, wr_ready, out_valid, out_data, out_last, done,
           sram_addr, sram_wen, sram_ren, sram_wdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_addr, wr_data, out_ready, sram_rdata,
    input  cmd_ready, wr_ready, out_valid, out_data, out_last, done,
           sram_addr, sram_wen, sram_ren, sram_wdata
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO, power-of-two depth
module sync_fifo_fwft
  import sram_stream_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_BIT = credit_bits(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [CNT_BIT-1:0] count
);
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_BIT-1:0] r_rd_ptr;
  logic [PTR_BIT-1:0] r_wr_ptr;
  logic [CNT_BIT-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BIT'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BIT'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_BIT'(1);
        2'b01:   r_count <= r_count - CNT_BIT'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CNT_BIT'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/sram_rd_streamer.sv
// rtl/sram_rd_streamer.sv - burst read engine for a single-port SRAM with write priority
module sram_rd_streamer
  import sram_stream_pkg::*;
#(
  parameter int DATA_BIT   = 64,
  parameter int DEPTH      = 1024,
  parameter int ADDR_BIT   = $clog2(DEPTH),
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  sram_rd_streamer_if.master bus
);
  localparam int CRED_BIT = credit_bits(FIFO_DEPTH);
  localparam int LEN_BIT  = ADDR_BIT + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ready_en;
  logic                r_done;
  logic [ADDR_BIT-1:0] r_cur_addr;
  logic [LEN_BIT-1:0]  r_len;
  logic [LEN_BIT-1:0]  r_issue_left;
  logic [LEN_BIT-1:0]  r_ret_cnt;
  logic [RD_LAT-1:0]   r_pipe;
  logic [CRED_BIT-1:0] w_inflight;
  logic [CRED_BIT-1:0] w_fifo_count;
  logic [CRED_BIT:0]   w_credit_used;
  logic [DATA_BIT-1:0] w_fifo_dout;
  logic w_wr_go, w_cmd_ready, w_credit_ok, w_issue, w_latch, w_done_nxt;
  logic w_push, w_pop, w_last, w_fifo_full, w_fifo_empty;

  assign w_wr_go     = bus.wr_valid && r_ready_en;
  assign w_cmd_ready = r_ready_en && (r_state == ST_IDLE);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CRED_BIT'(r_pipe[i]);
  end

  // Every read is reserved a FIFO slot at issue time, so returns can never overflow
  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, w_inflight};
  assign w_credit_ok   = w_credit_used < (CRED_BIT+1)'(FIFO_DEPTH);
  assign w_push        = r_pipe[RD_LAT-1];
  assign w_pop         = !w_fifo_empty && bus.out_ready;
  assign w_last        = !w_fifo_empty && ((r_ret_cnt + LEN_BIT'(1)) == r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_latch     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          w_latch = 1'b1;
          if (bus.cmd_len == '0) w_done_nxt  = 1'b1;
          else                   w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!w_wr_go && w_credit_ok) begin
          w_issue = 1'b1;
          if (r_issue_left == LEN_BIT'(1)) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((w_inflight == '0) && w_pop && w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready_en   <= 1'b0;
      r_done       <= 1'b0;
      r_cur_addr   <= '0;
      r_len        <= '0;
      r_issue_left <= '0;
      r_ret_cnt    <= '0;
      r_pipe       <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_done     <= w_done_nxt;
      r_pipe[0]  <= w_issue;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      if (w_latch) begin
        r_cur_addr   <= bus.cmd_addr;
        r_len        <= bus.cmd_len;
        r_issue_left <= bus.cmd_len;
        r_ret_cnt    <= '0;
      end else begin
        if (w_issue) begin
          r_cur_addr   <= (r_cur_addr == ADDR_BIT'(DEPTH - 1)) ? '0 : r_cur_addr + ADDR_BIT'(1);
          r_issue_left <= r_issue_left - LEN_BIT'(1);
        end
        if (w_pop) r_ret_cnt <= r_ret_cnt + LEN_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(w_push && w_fifo_full && !w_pop));
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.sram_rdata),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.wr_ready   = r_ready_en;
  assign bus.sram_wen   = w_wr_go;
  assign bus.sram_ren   = w_issue;
  assign bus.sram_addr  = w_wr_go ? bus.wr_addr : (w_issue ? r_cur_addr : '0);
  assign bus.sram_wdata = w_wr_go ? bus.wr_data : '0;
  assign bus.out_valid  = !w_fifo_empty;
  assign bus.out_data   = w_fifo_empty ? '0 : w_fifo_dout;
  assign bus.out_last   = w_last;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb/tb_sram_rd_streamer.sv - directed bench for sram_rd_streamer with an RD_LAT SRAM model
module tb_sram_rd_streamer;
  localparam int DATA_BIT   = 64;
  localparam int DEPTH      = 1024;
  localparam int ADDR_BIT   = 10;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_rd_streamer_if #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT)) bus ();

  sram_rd_streamer #(
    .DATA_BIT(DATA_BIT), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [63:0] pat(input int a);
    return {32'hC0DE_0000 | 32'(a), ~32'(a)};
  endfunction

  // SRAM model: ren sampled at an edge, data presented for capture RD_LAT edges later
  logic [63:0] ram [DEPTH];
  logic [63:0] rd_pipe [RD_LAT];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
      init_done <= 1'b1;
    end else if (bus.sram_wen) begin
      ram[bus.sram_addr] <= bus.sram_wdata;
    end
    rd_pipe[0] <= bus.sram_ren ? ram[bus.sram_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.sram_rdata = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] beat_q [$];
  bit          last_q [$];
  int          beat_cyc_q [$];
  int          ren_cyc_q [$];
  int          ren_addr_q [$];
  int          both_cnt = 0, issued = 0, popped = 0, max_out = 0, valid_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0;
      popped = 0;
    end else begin
      if (bus.sram_wen && bus.sram_ren) both_cnt++;
      if (issued - popped + int'(bus.sram_ren) > max_out) max_out = issued - popped + int'(bus.sram_ren);
      if (bus.sram_ren) begin
        issued++;
        ren_cyc_q.push_back(cyc);
        ren_addr_q.push_back(int'(bus.sram_addr));
      end
      if (bus.out_valid) valid_seen++;
      if (bus.out_valid && bus.out_ready) begin
        popped++;
        beat_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        beat_cyc_q.push_back(cyc);
      end
    end
  end

  logic [63:0] ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int a, input int l, output int acc_cyc);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = ADDR_BIT'(a);
    bus.cmd_len   = (ADDR_BIT+1)'(l);
    acc_cyc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok, output int done_cyc);
    ok = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.out_valid, bus.out_last, bus.done, bus.sram_wen, bus.sram_ren} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000000", {bus.cmd_ready, bus.wr_ready, bus.out_valid, bus.out_last, bus.done, bus.sram_wen, bus.sram_ren});
    end
    checks++;
    if (bus.sram_addr !== '0 || bus.sram_wdata !== '0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h out_data=%h want all 0", bus.sram_addr, bus.sram_wdata, bus.out_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_release_same got=%b want=0", bus.cmd_ready); end
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_next cmd_ready=%b wr_ready=%b want 1 1", bus.cmd_ready, bus.wr_ready);
    end
  endtask

  task automatic test_basic();
    int acc, dc, b0, r0, n;
    bit ok;
    for (int a = 0; a < 8; a++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = ADDR_BIT'(a); bus.wr_data = 64'(a);
      ref_mem[a] = 64'(a);
      #1;
      checks++;
      if (bus.sram_wen !== 1'b1 || bus.sram_ren !== 1'b0 || bus.sram_addr !== ADDR_BIT'(a) || bus.sram_wdata !== 64'(a)) begin
        failures++;
        $display("FAIL write_drive a=%0d wen=%b ren=%b addr=%0d wdata=%h", a, bus.sram_wen, bus.sram_ren, bus.sram_addr, bus.sram_wdata);
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    b0 = beat_q.size(); r0 = ren_cyc_q.size();
    start_cmd(0, 8, acc);
    wait_done(40, ok, dc);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done got=timeout want=pulse"); end
    n = beat_q.size() - b0;
    checks++;
    if (n != 8) begin failures++; $display("FAIL basic_count got=%0d want=8", n); end
    checks++;
    if (ren_cyc_q.size() <= r0 || ren_cyc_q[r0] != acc + 1) begin
      failures++; $display("FAIL basic_first_issue got=%0d want=%0d", (ren_cyc_q.size() > r0) ? ren_cyc_q[r0] : -1, acc + 1);
    end
    for (int k = 0; k < n && k < 8; k++) begin
      checks++;
      if (beat_q[b0+k] !== ref_mem[k] || last_q[b0+k] !== (k == 7) || beat_cyc_q[b0+k] != acc + 1 + RD_LAT + 1 + k) begin
        failures++;
        $display("FAIL basic_beat%0d data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", k, beat_q[b0+k], last_q[b0+k],
                 beat_cyc_q[b0+k], ref_mem[k], (k == 7), acc + 1 + RD_LAT + 1 + k);
      end
    end
    checks++;
    if (dc != acc + 12) begin failures++; $display("FAIL basic_done_cycle got=%0d want=%0d", dc, acc + 12); end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_with_done got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic test_wrap();
    int acc, dc, b0, r0, n, ea;
    bit ok;
    b0 = beat_q.size(); r0 = ren_cyc_q.size();
    start_cmd(1022, 4, acc);
    wait_done(40, ok, dc);
    n = beat_q.size() - b0;
    checks++;
    if (!ok || n != 4 || ren_addr_q.size() - r0 != 4) begin
      failures++; $display("FAIL wrap_count done=%b beats=%0d issues=%0d want 1 4 4", ok, n, ren_addr_q.size() - r0);
    end
    for (int k = 0; k < n && k < 4; k++) begin
      ea = (1022 + k) % DEPTH;
      checks++;
      if (beat_q[b0+k] !== ref_mem[ea] || ren_addr_q[r0+k] != ea || last_q[b0+k] !== (k == 3)) begin
        failures++;
        $display("FAIL wrap_beat%0d data=%h addr=%0d last=%b want data=%h addr=%0d last=%b", k, beat_q[b0+k],
                 ren_addr_q[r0+k], last_q[b0+k], ref_mem[ea], ea, (k == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, b0, r0, n, span;
    bit ok;
    b0 = beat_q.size(); r0 = ren_cyc_q.size();
    start_cmd(100, 16, acc);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      bus.out_ready = (i % 4 == 0);
      tick();
      if (bus.done === 1'b1) ok = 1'b1;
    end
    bus.out_ready = 1'b1;
    n = beat_q.size() - b0;
    checks++;
    if (!ok || n != 16) begin failures++; $display("FAIL bp_count done=%b beats=%0d want 1 16", ok, n); end
    for (int k = 0; k < n && k < 16; k++) begin
      checks++;
      if (beat_q[b0+k] !== ref_mem[100+k] || last_q[b0+k] !== (k == 15)) begin
        failures++;
        $display("FAIL bp_beat%0d data=%h last=%b want data=%h last=%b", k, beat_q[b0+k], last_q[b0+k], ref_mem[100+k], (k == 15));
      end
    end
    checks++;
    if (max_out > FIFO_DEPTH) begin failures++; $display("FAIL bp_credit max_outstanding=%0d want<=%0d", max_out, FIFO_DEPTH); end
    span = (ren_cyc_q.size() - r0 == 16) ? ren_cyc_q[r0+15] - ren_cyc_q[r0] : -1;
    checks++;
    if (span <= 15) begin failures++; $display("FAIL bp_stall issue_span=%0d want>15", span); end
  endtask

  task automatic test_write_during_burst();
    int acc, dc, b0, r0, n, both0, span;
    bit ok;
    logic [63:0] exp_q [8];
    for (int k = 0; k < 8; k++) exp_q[k] = ref_mem[200+k];
    exp_q[6] = 64'h1111_2222_3333_4444;
    both0 = both_cnt;
    b0 = beat_q.size(); r0 = ren_cyc_q.size();
    start_cmd(200, 8, acc);
    tick();
    for (int w = 0; w < 2; w++) begin
      tick();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = (w == 0) ? ADDR_BIT'(200) : ADDR_BIT'(206);
      bus.wr_data  = (w == 0) ? 64'h5555_6666_7777_8888 : 64'h1111_2222_3333_4444;
      #1;
      checks++;
      if (bus.sram_ren !== 1'b0 || bus.sram_wen !== 1'b1 || bus.sram_addr !== bus.wr_addr) begin
        failures++; $display("FAIL wdb_priority w=%0d ren=%b wen=%b addr=%0d want 0 1 %0d", w, bus.sram_ren, bus.sram_wen, bus.sram_addr, bus.wr_addr);
      end
    end
    ref_mem[200] = 64'h5555_6666_7777_8888;
    ref_mem[206] = 64'h1111_2222_3333_4444;
    tick();
    bus.wr_valid = 1'b0;
    wait_done(40, ok, dc);
    n = beat_q.size() - b0;
    checks++;
    if (!ok || n != 8) begin failures++; $display("FAIL wdb_count done=%b beats=%0d want 1 8", ok, n); end
    for (int k = 0; k < n && k < 8; k++) begin
      checks++;
      if (beat_q[b0+k] !== exp_q[k]) begin failures++; $display("FAIL wdb_beat%0d got=%h want=%h", k, beat_q[b0+k], exp_q[k]); end
    end
    span = (ren_cyc_q.size() - r0 == 8) ? ren_cyc_q[r0+7] - ren_cyc_q[r0] : -1;
    checks++;
    if (span != 9) begin failures++; $display("FAIL wdb_stretch issue_span=%0d want=9", span); end
    checks++;
    if (both_cnt != both0) begin failures++; $display("FAIL wdb_exclusive both_seen=%0d want=%0d", both_cnt, both0); end
  endtask

  task automatic test_len_zero();
    int acc, r0, v0;
    r0 = ren_cyc_q.size(); v0 = valid_seen;
    start_cmd(5, 0, acc);
    checks++;
    if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL len0_done done=%b cmd_ready=%b want 1 1", bus.done, bus.cmd_ready);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL len0_pulse got=%b want=0", bus.done); end
    tick(); tick(); tick();
    checks++;
    if (ren_cyc_q.size() != r0 || valid_seen != v0) begin
      failures++; $display("FAIL len0_quiet issues=%0d valids=%0d want 0 0", ren_cyc_q.size() - r0, valid_seen - v0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int acc, dc, b0, r0, v0, n;
    bit ok;
    b0 = beat_q.size();
    start_cmd(300, 8, acc);
    for (int i = 0; i < 30 && (beat_q.size() - b0 < 3); i++) tick();
    checks++;
    if (beat_q.size() - b0 != 3) begin failures++; $display("FAIL rmb_pre_beats got=%0d want=3", beat_q.size() - b0); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.cmd_ready, bus.out_valid, bus.out_last, bus.done, bus.sram_wen, bus.sram_ren} !== 6'b0 ||
        bus.sram_addr !== '0 || bus.out_data !== '0 || bus.sram_wdata !== '0) begin
      failures++;
      $display("FAIL rmb_reset_vals ctrl=%b addr=%h out_data=%h want 000000 0 0",
               {bus.cmd_ready, bus.out_valid, bus.out_last, bus.done, bus.sram_wen, bus.sram_ren}, bus.sram_addr, bus.out_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rmb_ready got=%b want=1", bus.cmd_ready); end
    v0 = valid_seen; b0 = beat_q.size(); r0 = ren_cyc_q.size();
    start_cmd(400, 4, acc);
    tick(); tick();
    checks++;
    if (valid_seen != v0) begin failures++; $display("FAIL rmb_stale valids=%0d want=0", valid_seen - v0); end
    wait_done(40, ok, dc);
    n = beat_q.size() - b0;
    checks++;
    if (!ok || n != 4 || ren_cyc_q.size() <= r0 || ren_cyc_q[r0] != acc + 1) begin
      failures++; $display("FAIL rmb_new_burst done=%b beats=%0d want 1 4 issue at %0d", ok, n, acc + 1);
    end
    for (int k = 0; k < n && k < 4; k++) begin
      checks++;
      if (beat_q[b0+k] !== ref_mem[400+k]) begin failures++; $display("FAIL rmb_beat%0d got=%h want=%h", k, beat_q[b0+k], ref_mem[400+k]); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_write_during_burst();
    test_len_zero();
    test_reset_mid_burst();
    checks++;
    if (both_cnt != 0) begin failures++; $display("FAIL global_exclusive both_seen=%0d want=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_rd_streamer.md
Name: sram_rd_streamer

Overview:
- Read-stream engine sitting directly upstream of the single-port SRAM wrapper (sram_sp_sky130).
- Accepts a burst read command (base address, length) and issues one SRAM read per cycle. Returns data on a valid/ready stream with last-beat marking.
- Absorbs the SRAM's fixed read latency with a credit-limited output FIFO, so downstream backpressure never drops data.
- Also arbitrates a single write port onto the same SRAM; writes have priority.

Parameters:
- DATA_BIT, 64, SRAM word width; multiple of 32.
- DEPTH, 1024, SRAM words; power of two.
- ADDR_BIT, $clog2(DEPTH), address width.
- RD_LAT, 2, cycles from sram_ren high at a clock edge to sram_rdata valid for capture.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_BIT  burst base word address
- cmd_len  in  ADDR_BIT+1  beats, 0..DEPTH
- wr_valid  in  1  write request
- wr_ready  out  1  always 1 when out of reset
- wr_addr  in  ADDR_BIT  write address
- wr_data  in  DATA_BIT  write data
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_BIT  stream data
- out_last  out  1  final beat of burst
- done  out  1  one-cycle pulse when a burst completes
- sram_addr  out  ADDR_BIT  to wrapper addr
- sram_wen  out  1  to wrapper wen
- sram_ren  out  1  to wrapper ren
- sram_wdata  out  DATA_BIT  to wrapper wdata
- sram_rdata  in  DATA_BIT  from wrapper rdata

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values (all outputs): cmd_ready=0 during reset, 1 the cycle after release; out_valid=0, out_last=0, done=0, sram_wen=0, sram_ren=0, sram_addr=0, sram_wdata=0, out_data=0.
- Reset mid-burst: FSM returns to IDLE; FIFO, in-flight pipe and counters are cleared. Data already in flight is discarded and never reaches out_*.

FSM:
- IDLE: on cmd_valid&&cmd_ready, latch addr and len.
  - len==0: done pulses next cycle, stay IDLE.
  - Otherwise go to ISSUE.
- ISSUE: read issue conditions:
  - A read issues in a cycle when !wr_valid && (fifo_count + inflight) < FIFO_DEPTH.
  - On issue: sram_ren=1, sram_addr=cur_addr, cur_addr increments modulo DEPTH (wraps DEPTH-1 -> 0), issue counter decrements.
  - When the last read issues, go to DRAIN.
- DRAIN: wait until inflight==0 and the last beat has been accepted (out_valid&&out_ready&&out_last), then done=1 for one cycle and return to IDLE. cmd_ready rises in the same cycle as done.

Writes:
- Any state, wr_valid -> sram_wen=1, sram_ren=0, sram_addr=wr_addr, sram_wdata=wr_data, same cycle (combinational drive). The read issue stalls that cycle.
- sram_wen and sram_ren are never both 1.
- Read-vs-write ordering follows SRAM issue order: a read issued before a write to the same address returns old data.

Read return and FIFO:
- In-flight tracking: RD_LAT-deep shift register of issue bits; the bit exiting the pipe pushes sram_rdata into the FIFO.
- The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.
- out_valid = FIFO non-empty; out_data = FIFO head (first-word fall-through).
- Push and pop in the same cycle are allowed when full or empty.
- out_last is 1 on the beat whose return count equals the latched len.
- Sustained throughput is 1 beat/cycle when out_ready=1 and FIFO_DEPTH >= RD_LAT+1.
- Beats are returned in address order.

Widths: cmd_len is ADDR_BIT+1 bits so that a full-memory burst (len=DEPTH) is legal. All counters are ADDR_BIT+1 bits.

Decomposition:
- Shared package sram_stream_pkg: FSM state enum (IDLE/ISSUE/DRAIN) and a localparam helper for the credit-width clog2(FIFO_DEPTH+1).
- One sub-module: sync_fifo_fwft (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). It is reusable for other SRAM-side streams.
- The FSM, credit logic and latency pipe stay in the top module.

Test Plan:
- Preload words 0..7 with value=addr via the write port; cmd addr=0 len=8 with out_ready=1 -> beats 0..7 on 8 consecutive cycles starting RD_LAT+1 cycles after issue; out_last on beat 7; done one cycle later.
- Wrap: DEPTH=1024, cmd addr=1022 len=4 -> beats read addresses 1022, 1023, 0, 1 in order.
- Backpressure: len=16, out_ready toggling 1 cycle on / 3 off -> all 16 beats in order, no loss; fifo_count+inflight never exceeds 4; sram_ren stalls when credits are exhausted.
- Write during burst: wr_valid on cycles 2 and 3 of a len=8 burst -> sram_ren=0 on those cycles, the burst stretches by 2 cycles, data is correct, sram_wen&&sram_ren is never observed.
- len=0 -> no sram_ren and no out_valid; done pulses on the cycle after acceptance.
- Reset mid-burst: rst_n=0 for 1 cycle after 3 beats of len=8 -> all outputs at reset values; no further out_valid; a new cmd is accepted the cycle after release and streams correct data.
